count_decoder: RTL and testbench

COUNT_DECODER -- requirements
Module: count_decoder

---
 rtl/count_decoder_if.sv | 28 ++
 rtl/count_decoder.sv | 136 +++++++++++++
 tb/tb_count_decoder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_decoder_if.sv
// Sample/result bundle for the 2-bit up/down count decoder.
// Master drives samples; slave returns decoded motion and error status.
interface count_decoder_if #(
  parameter int POS_W = 8,
  parameter int ERR_W = 4
);
  logic                    valid;
  logic [1:0]              count;
  logic                    clear;
  logic                    dir_up;
  logic                    dir_down;
  logic signed [POS_W-1:0] position;
  logic                    err_jump;
  logic [ERR_W-1:0]        err_count;
  logic                    locked;

  modport master (
    output valid, count, clear,
    input  dir_up, dir_down, position,
    input  err_jump, err_count, locked
  );

  modport slave (
    input  valid, count, clear,
    output dir_up, dir_down, position,
    output err_jump, err_count, locked
  );
endinterface

// File: rtl/count_decoder.sv
// Tracks a 2-bit up/down counter as a signed position with
// illegal-jump detection and two-sample resynchronisation.
module count_decoder #(
  parameter int POS_W = 8,
  parameter int ERR_W = 4
) (
  input logic             clk,
  input logic             reset,
  count_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         prev_q, prev_d;
  logic               streak_q, streak_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               up_q, up_d;
  logic               dn_q, dn_d;
  logic               jump_q, jump_d;

  logic [1:0]         delta;
  logic               is_hold, is_up;
  logic               is_dn, is_bad;
  logic [ERR_W-1:0]   err_inc;

  assign delta   = bus.count - prev_q;
  assign is_hold = (delta == 2'd0);
  assign is_up   = (delta == 2'd1);
  assign is_bad  = (delta == 2'd2);
  assign is_dn   = (delta == 2'd3);
  assign err_inc = (&err_q) ? err_q
                 : err_q + ERR_W'(1);

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    streak_d = streak_q;
    pos_d    = pos_q;
    err_d    = err_q;
    up_d     = up_q;
    dn_d     = dn_q;
    jump_d   = 1'b0;
    if (bus.clear) begin
      state_d  = IDLE;
      prev_d   = 2'd0;
      streak_d = 1'b0;
      pos_d    = '0;
      err_d    = '0;
      up_d     = 1'b0;
      dn_d     = 1'b0;
    end else if (bus.valid) begin
      prev_d = bus.count;
      up_d   = 1'b0;
      dn_d   = 1'b0;
      unique case (state_q)
        IDLE: begin
          state_d  = TRACK;
          streak_d = 1'b0;
        end
        TRACK: begin
          unique case (1'b1)
            is_hold: ;
            is_up: begin
              pos_d = pos_q + POS_W'(1);
              up_d  = 1'b1;
            end
            is_dn: begin
              pos_d = pos_q - POS_W'(1);
              dn_d  = 1'b1;
            end
            is_bad: begin
              jump_d   = 1'b1;
              err_d    = err_inc;
              state_d  = RESYNC;
              streak_d = 1'b0;
            end
            default: ;
          endcase
        end
        RESYNC: begin
          // second legal sample in a row re-locks but is not applied
          if (is_bad) begin
            jump_d   = 1'b1;
            err_d    = err_inc;
            streak_d = 1'b0;
          end else if (streak_q) begin
            state_d  = TRACK;
            streak_d = 1'b0;
          end else begin
            streak_d = 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          streak_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      prev_q   <= 2'd0;
      streak_q <= 1'b0;
      pos_q    <= '0;
      err_q    <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      jump_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      streak_q <= streak_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      jump_q   <= jump_d;
    end
  end

  assign bus.position  = pos_q;
  assign bus.err_count = err_q;
  assign bus.dir_up    = up_q;
  assign bus.dir_down  = dn_q;
  assign bus.err_jump  = jump_q;
  assign bus.locked    = (state_q == TRACK);

endmodule

// File: tb/tb_count_decoder.sv
// Directed bench for count_decoder: lock, steps, resync,
// saturation, wrap, async reset and clear priority.
module tb_count_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  count_decoder_if #(.POS_W(8), .ERR_W(4)) bus ();

  count_decoder #(.POS_W(8), .ERR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [1:0] c,
                      input logic clr);
    @(negedge clk);
    bus.valid = v;
    bus.count = c;
    bus.clear = clr;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] obs;
    bus.valid = 1'b0;
    bus.count = 2'd0;
    bus.clear = 1'b0;
    reset = 1'b0;
    #3;
    obs = {bus.position, bus.err_count, bus.dir_up,
           bus.dir_down, bus.err_jump, bus.locked};
    n_tests++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got %h want 0000", obs);
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 2'd1, 1'b0);
    n_tests++;
    if (bus.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_valid locked got %b want 0", bus.locked);
    end
  endtask

  task automatic test_up;
    step(1'b1, 2'd0, 1'b0);
    n_tests++;
    if (bus.locked !== 1'b1 || bus.position !== 8'sd0 ||
        bus.dir_up !== 1'b0 || bus.err_jump !== 1'b0) begin
      n_fail++;
      $display("FAIL up_first_lock got lk=%b pos=%0d up=%b ej=%b want 1 0 0 0",
               bus.locked, bus.position, bus.dir_up, bus.err_jump);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 2'(i), 1'b0);
      n_tests++;
      if (bus.dir_up !== 1'b1 || bus.dir_down !== 1'b0 ||
          bus.position !== 8'(i)) begin
        n_fail++;
        $display("FAIL up_step%0d got up=%b dn=%b pos=%0d want 1 0 %0d",
                 i, bus.dir_up, bus.dir_down, bus.position, i);
      end
    end
    step(1'b0, 2'd2, 1'b0);
    n_tests++;
    if (bus.dir_up !== 1'b1 || bus.position !== 8'sd4 ||
        bus.err_jump !== 1'b0) begin
      n_fail++;
      $display("FAIL up_idle_hold got up=%b pos=%0d ej=%b want 1 4 0",
               bus.dir_up, bus.position, bus.err_jump);
    end
  endtask

  task automatic test_down;
    logic [1:0] seq [3];
    seq = '{2'd1, 2'd0, 2'd3};
    step(1'b0, 2'd0, 1'b1);
    step(1'b1, 2'd2, 1'b0);
    foreach (seq[i]) step(1'b1, seq[i], 1'b0);
    n_tests++;
    if (bus.position !== 8'hFD || bus.dir_down !== 1'b1 ||
        bus.dir_up !== 1'b0 || bus.err_count !== 4'd0) begin
      n_fail++;
      $display("FAIL down_seq got pos=%h dn=%b up=%b ec=%0d want fd 1 0 0",
               bus.position, bus.dir_down, bus.dir_up, bus.err_count);
    end
    step(1'b1, 2'd3, 1'b0);
    n_tests++;
    if (bus.dir_down !== 1'b0 || bus.dir_up !== 1'b0 ||
        bus.position !== 8'hFD) begin
      n_fail++;
      $display("FAIL down_hold got dn=%b up=%b pos=%h want 0 0 fd",
               bus.dir_down, bus.dir_up, bus.position);
    end
  endtask

  task automatic test_resync;
    step(1'b0, 2'd0, 1'b1);
    step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    n_tests++;
    if (bus.err_jump !== 1'b1 || bus.err_count !== 4'd1 ||
        bus.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_jump got ej=%b ec=%0d lk=%b want 1 1 0",
               bus.err_jump, bus.err_count, bus.locked);
    end
    step(1'b0, 2'd2, 1'b0);
    n_tests++;
    if (bus.err_jump !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_pulse_width got ej=%b want 0", bus.err_jump);
    end
    step(1'b1, 2'd3, 1'b0);
    n_tests++;
    if (bus.locked !== 1'b0 || bus.dir_up !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_first_legal got lk=%b up=%b want 0 0",
               bus.locked, bus.dir_up);
    end
    step(1'b1, 2'd0, 1'b0);
    n_tests++;
    if (bus.locked !== 1'b1 || bus.position !== 8'sd0 ||
        bus.dir_up !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_relock got lk=%b pos=%0d up=%b want 1 0 0",
               bus.locked, bus.position, bus.dir_up);
    end
    step(1'b1, 2'd1, 1'b0);
    n_tests++;
    if (bus.position !== 8'sd1 || bus.dir_up !== 1'b1) begin
      n_fail++;
      $display("FAIL resync_track_up got pos=%0d up=%b want 1 1",
               bus.position, bus.dir_up);
    end
  endtask

  task automatic test_saturate;
    int pulses;
    pulses = 0;
    step(1'b0, 2'd0, 1'b1);
    step(1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (i % 2 == 0) ? 2'd2 : 2'd0, 1'b0);
      if (bus.err_jump === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 20) begin
      n_fail++;
      $display("FAIL sat_pulses got %0d want 20", pulses);
    end
    n_tests++;
    if (bus.err_count !== 4'd15 || bus.position !== 8'sd0) begin
      n_fail++;
      $display("FAIL sat_count got ec=%0d pos=%0d want 15 0",
               bus.err_count, bus.position);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] obs;
    int both;
    both = 0;
    step(1'b0, 2'd0, 1'b1);
    step(1'b1, 2'd0, 1'b0);
    for (int i = 1; i <= 128; i++) begin
      step(1'b1, 2'(i), 1'b0);
      if (bus.dir_up && bus.dir_down) both++;
      if (i == 127) begin
        n_tests++;
        if (bus.position !== 8'sd127) begin
          n_fail++;
          $display("FAIL wrap_127 got %0d want 127", bus.position);
        end
      end
    end
    n_tests++;
    if (bus.position !== 8'h80 || both != 0) begin
      n_fail++;
      $display("FAIL wrap_128 got pos=%h both=%0d want 80 0",
               bus.position, both);
    end
    #2;
    reset = 1'b0;
    #1;
    obs = {bus.position, bus.err_count, bus.dir_up,
           bus.dir_down, bus.err_jump, bus.locked};
    n_tests++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset got %h want 0000", obs);
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 2'd3, 1'b0);
    n_tests++;
    if (bus.locked !== 1'b1 || bus.position !== 8'sd0 ||
        bus.dir_up !== 1'b0 || bus.dir_down !== 1'b0 ||
        bus.err_jump !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_lock got lk=%b pos=%0d up=%b dn=%b ej=%b",
               bus.locked, bus.position, bus.dir_up, bus.dir_down,
               bus.err_jump);
    end
  endtask

  task automatic test_clear_priority;
    step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    step(1'b1, 2'd3, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    n_tests++;
    if (bus.locked !== 1'b1 || bus.position !== 8'sd1 ||
        bus.err_count !== 4'd1) begin
      n_fail++;
      $display("FAIL clr_setup got lk=%b pos=%0d ec=%0d want 1 1 1",
               bus.locked, bus.position, bus.err_count);
    end
    step(1'b1, 2'd1, 1'b1);
    n_tests++;
    if (bus.position !== 8'sd0 || bus.err_count !== 4'd0 ||
        bus.locked !== 1'b0 || bus.dir_up !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_prio got pos=%0d ec=%0d lk=%b up=%b want 0 0 0 0",
               bus.position, bus.err_count, bus.locked, bus.dir_up);
    end
    step(1'b1, 2'd2, 1'b0);
    n_tests++;
    if (bus.locked !== 1'b1 || bus.position !== 8'sd0 ||
        bus.dir_up !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_relock got lk=%b pos=%0d up=%b want 1 0 0",
               bus.locked, bus.position, bus.dir_up);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_resync();
    test_saturate();
    test_wrap();
    test_clear_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
